jtcontra_snd_cmdq: RTL
======================

Name: jtcontra_snd_cmdq

Overview:
Parametrised command queue between the main CPU and the sound CPU. It replaces the single sound latch plus edge flip-flop IRQ pair.
- Buffers up to DEPTH command bytes written by the main CPU.
- Presents the oldest byte to the sound CPU's latch read.
- Drives the sound CPU int_n through an ack-aware request state machine.
- Sits in the game top, between the main CPU write decode and the sound subsystem's latch_cs / irq_ack decode.

Parameters:
DW, 8, command width in bits
DEPTH, 4, queue entries; power of two, 1..64
LATCH_MODE, 0, 1 = single-entry overwrite latch (forces DEPTH=1, no overflow); 0 = FIFO
IRQ_PER_CMD, 1, 1 = one IRQ request per queued command; 0 = level request while queue non-empty
EMPTY_VAL, 8'hff, value on snd_dout while the queue is empty (width DW)

Ports:
clk  in  1  system clock (24 MHz)
rst  in  1  synchronous reset, active high
main_wr  in  1  one-cycle push strobe from main CPU write decode
main_din  in  DW  command byte to push
snd_rd  in  1  one-cycle pop strobe; sound side generates it on the trailing edge of a latch_cs read
irq_ack  in  1  sound CPU interrupt acknowledge (!m1_n && !iorq_n), level, may last several clk
snd_dout  out  DW  head of queue, or EMPTY_VAL when empty
int_n  out  1  sound CPU interrupt, active low
empty  out  1  queue empty
full  out  1  queue full
level  out  $clog2(DEPTH)+1  number of stored entries
ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf

Behaviour:
Reset values:
- Pointers 0, level 0, empty=1, full=0, ovf=0, int_n=1.
- snd_dout=EMPTY_VAL.
- Storage contents are not cleared.
- Reset asserted mid-transfer discards all entries and any pending request. The next cycle behaves as after power-up.

Read path:
- snd_dout is combinational from the head register: zero-latency read for the Z80 data bus.
- A push into an empty queue appears on snd_dout one clk after main_wr.

Push (FIFO mode):
- main_wr && !full: store at wr_ptr, wr_ptr+1 (wraps modulo DEPTH), level+1.
- main_wr && full && !snd_rd: byte dropped, ovf<=1, no other state change.
- main_wr && full && snd_rd same cycle: pop and push both take effect, level unchanged, ovf unchanged.

Pop:
- snd_rd && !empty: rd_ptr+1 (wraps), level-1.
- snd_rd && empty: ignored, no underflow, pointers unchanged.
- Simultaneous push and pop on a non-empty, non-full queue: level unchanged, both pointers advance.
- Simultaneous push and pop on an empty queue: push only. The new byte is not popped.

ovf:
- ovf_clr clears ovf.
- If ovf_clr and a new overflow occur in the same cycle, the set wins.

LATCH_MODE=1:
- Push always overwrites the single entry and sets level=1.
- snd_rd clears level to 0.
- snd_dout holds the last written value even when empty; EMPTY_VAL is not used.
- ovf stays 0.

IRQ state machine (states IDLE, REQ, ACKED):
- IDLE: int_n=1. Go to REQ when level!=0 (evaluated on the registered level).
- REQ: int_n=0. On irq_ack, go to ACKED.
- ACKED: int_n=1. Exit depends on IRQ_PER_CMD:
  - IRQ_PER_CMD=1: leave on the first pop (snd_rd with !empty) to IDLE. IDLE re-requests if entries remain, giving a minimum one-cycle int_n high gap between requests. Further acks while in ACKED are ignored.
  - IRQ_PER_CMD=0: return to IDLE when level reaches 0.
- Pushes while in REQ or ACKED create no extra request. They are served by the re-evaluation in IDLE.
- irq_ack arriving in IDLE is ignored.
- If the queue is emptied while in REQ, int_n still stays low until irq_ack (no retraction, matching Z80 sampling).

Decomposition:
Package jtcontra_snd_pkg holds:
- the IRQ state encoding (IDLE=2'd0, REQ=2'd1, ACKED=2'd2);
- a log2 helper for the level width.

One sub-module: jtcontra_snd_fifo (DW, DEPTH), covering storage, pointers, level, empty/full and simultaneous push/pop handling. The top adds LATCH_MODE muxing, ovf and the IRQ FSM.

Test Plan:
1. Reset, then push 8'h12 -> next clk snd_dout=12, level=1, int_n=0 one clk later. irq_ack for 3 clk -> int_n=1. snd_rd -> empty=1, snd_dout=FF, int_n stays 1.
2. DEPTH=4: push 01,02,03,04,05 -> full=1 after 04, 05 dropped, ovf=1. Pop four times -> snd_dout sequence 01,02,03,04. ovf_clr -> ovf=0.
3. IRQ_PER_CMD=1: push A0,A1, then ack+pop A0 -> int_n high for at least 1 clk, then low again. Ack+pop A1 -> int_n stays 1.
4. Full queue with main_wr+snd_rd in the same cycle -> level stays 4, ovf=0, new byte emerges last. Empty queue with main_wr+snd_rd together -> level=1.
5. LATCH_MODE=1: push 33 then 44 without a read -> snd_dout=44, ovf=0. snd_rd -> level=0, snd_dout stays 44.
6. rst asserted while in REQ with 3 entries -> next cycle int_n=1, level=0, snd_dout=FF. A push afterward behaves as scenario 1.

Source files
------------

// File: rtl/jtcontra_snd_pkg.sv
// Shared types for the sound command queue: IRQ request states and level-width helper.
package jtcontra_snd_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE  = 2'd0,
    IRQ_REQ   = 2'd1,
    IRQ_ACKED = 2'd2
  } irq_st_t;

  // Level counter must represent 0..DEPTH inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/jtcontra_snd_fifo.sv
// Circular command buffer with occupancy counter; head is visible combinationally.
// Push on full is accepted only when a pop frees the head slot in the same cycle.
module jtcontra_snd_fifo
  import jtcontra_snd_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [DW-1:0]           din_i,
  input  logic                    pop_i,
  output logic [DW-1:0]           dout_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [lvl_w(DEPTH)-1:0] level_o,
  output logic                    drop_o
);

  localparam int LW = lvl_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_FULL);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop on an empty queue never lets a same-cycle push bypass storage.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !pop_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/jtcontra_snd_cmdq.sv
// Main-to-sound CPU command queue (FIFO or overwrite latch) with an ack-aware int_n request FSM.
// snd_dout is combinational from the head; int_n follows the registered level by one clk.
module jtcontra_snd_cmdq
  import jtcontra_snd_pkg::*;
#(
  parameter int            DW          = 8,
  parameter int            DEPTH       = 4,
  parameter bit            LATCH_MODE  = 1'b0,
  parameter bit            IRQ_PER_CMD = 1'b1,
  parameter logic [DW-1:0] EMPTY_VAL   = DW'(8'hff)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    main_wr,
  input  logic [DW-1:0]           main_din,
  input  logic                    snd_rd,
  input  logic                    irq_ack,
  output logic [DW-1:0]           snd_dout,
  output logic                    int_n,
  output logic                    empty,
  output logic                    full,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int LW = lvl_w(DEPTH);

  logic    ovf_set;
  logic    ovf_q, ovf_d;
  logic    pop_ok;
  irq_st_t st_q, st_d;

  generate
    if (LATCH_MODE) begin : g_latch
      logic [DW-1:0] latch_q, latch_d;
      logic          vld_q, vld_d;

      // A write in the same cycle as a read keeps the new byte pending.
      always_comb begin
        latch_d = latch_q;
        vld_d   = vld_q;
        if (main_wr) begin
          latch_d = main_din;
          vld_d   = 1'b1;
        end else if (snd_rd) begin
          vld_d   = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          latch_q <= EMPTY_VAL;
          vld_q   <= 1'b0;
        end else begin
          latch_q <= latch_d;
          vld_q   <= vld_d;
        end
      end

      assign snd_dout = latch_q;
      assign empty    = !vld_q;
      assign full     = vld_q;
      assign level    = LW'(vld_q);
      assign ovf_set  = 1'b0;
    end else begin : g_fifo
      logic [DW-1:0] head;

      jtcontra_snd_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (main_wr),
        .din_i   (main_din),
        .pop_i   (snd_rd),
        .dout_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .level_o (level),
        .drop_o  (ovf_set)
      );

      assign snd_dout = empty ? EMPTY_VAL : head;
    end
  endgenerate

  assign pop_ok = snd_rd && !empty;

  // A fresh overflow outranks a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_comb begin
    st_d  = st_q;
    int_n = 1'b1;
    case (st_q)
      IRQ_IDLE: begin
        if (level != '0) st_d = IRQ_REQ;
      end
      IRQ_REQ: begin
        int_n = 1'b0;
        // Never retract: the Z80 may already have sampled the request.
        if (irq_ack) st_d = IRQ_ACKED;
      end
      IRQ_ACKED: begin
        if (IRQ_PER_CMD) begin
          if (pop_ok) st_d = IRQ_IDLE;
        end else begin
          if (level == '0) st_d = IRQ_IDLE;
        end
      end
      default: st_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IRQ_IDLE;
      ovf_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule
